// File: rtl/operand_fetch.sv
// Operand-fetch stage: 16 x 32-bit register file, register index decode,
// immediate extension and PC-relative branch target generation.
// All outputs are combinational from inst/pc/isRet/isSt and the array contents.
module operand_fetch #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int RA_REG   = 15
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [31:0]       inst,
    input  logic [31:0]       pc,
    input  logic              isRet,
    input  logic              isSt,
    input  logic              isWa,
    input  logic [3:0]        wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [31:0]       immx,
    output logic [31:0]       branchTarget
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [3:0]  field_a;
    logic [3:0]  field_b;
    logic [1:0]  mod;
    logic [15:0] imm;
    logic [26:0] off;
    logic [3:0]  rd_idx1;
    logic [3:0]  rd_idx2;

    // Opcode is decoded further down the pipe; it is not needed here.
    logic [4:0]  unused_opcode;

    assign unused_opcode = inst[31:27];
    assign field_a       = inst[25:22];
    assign field_b       = inst[21:18];
    assign mod           = inst[17:16];
    assign imm           = inst[15:0];
    assign off           = inst[26:0];

    // Register file update: reset clears every entry and wins over a write.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (isWa) begin
            regs[wa] <= wd;
        end
    end

    // Read index selection: ret reads the return-address register, stores
    // swap the two index fields so op2 carries the data to be stored.
    always_comb begin
        rd_idx1 = field_a;
        rd_idx2 = field_b;
        if (isRet) begin
            rd_idx1 = 4'(RA_REG);
        end else if (isSt) begin
            rd_idx1 = field_b;
        end
        if (isSt) begin
            rd_idx2 = field_a;
        end
    end

    // Combinational reads with no write bypass; new data appears after the edge.
    always_comb begin
        op1 = regs[rd_idx1];
        op2 = regs[rd_idx2];
    end

    // Immediate extension selected by the modifier bits.
    always_comb begin
        immx = {{16{imm[15]}}, imm};
        case (mod)
            2'b01:   immx = {16'h0000, imm};
            2'b10:   immx = {imm, 16'h0000};
            default: immx = {{16{imm[15]}}, imm};
        endcase
    end

    // Branch target: word offset sign-extended and scaled by 4, wraps mod 2^32.
    always_comb begin
        branchTarget = pc + {{3{off[26]}}, off, 2'b00};
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with an expectation queue checked after
// each stimulus step.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        isRet;
    logic        isSt;
    logic        isWa;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] immx;
    logic [31:0] branchTarget;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    localparam int S_OP1 = 0;
    localparam int S_OP2 = 1;
    localparam int S_IMM = 2;
    localparam int S_BT  = 3;

    operand_fetch dut (
        .clk          (clk),
        .Reset        (Reset),
        .inst         (inst),
        .pc           (pc),
        .isRet        (isRet),
        .isSt         (isSt),
        .isWa         (isWa),
        .wa           (wa),
        .wd           (wd),
        .op1          (op1),
        .op2          (op2),
        .immx         (immx),
        .branchTarget (branchTarget)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] m, input logic [15:0] i);
        return {5'b00000, 1'b0, a, b, m, i};
    endfunction

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            S_OP1:   return op1;
            S_OP2:   return op2;
            S_IMM:   return immx;
            default: return branchTarget;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_pending();
        exp_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = get_out(e.sel);
            n_asserts++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        isWa = 1'b1;
        wa   = a;
        wd   = d;
        @(negedge clk);
        isWa = 1'b0;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic r, input logic s);
        @(negedge clk);
        inst  = i;
        pc    = p;
        isRet = r;
        isSt  = s;
    endtask

    initial begin
        Reset = 1'b1;
        inst  = '0;
        pc    = '0;
        isRet = 1'b0;
        isSt  = 1'b0;
        isWa  = 1'b0;
        wa    = '0;
        wd    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;

        // Every register reads zero after reset, through both fields.
        for (int i = 0; i < 16; i++) begin
            drive(mk(4'(i), 4'(15 - i), 2'b00, 16'h0000), 32'h0, 1'b0, 1'b0);
            expect_out($sformatf("rst_op1_r%0d", i), S_OP1, 32'h0);
            expect_out($sformatf("rst_op2_r%0d", 15 - i), S_OP2, 32'h0);
            #1 check_pending();
        end

        write_reg(4'd4, 32'h12345678);
        write_reg(4'd5, 32'hCAFEBABE);
        write_reg(4'd15, 32'h0F0F0F0F);

        // Field decode and immediate modes.
        drive(mk(4'd4, 4'd5, 2'b00, 16'h8001), 32'h0, 1'b0, 1'b0);
        expect_out("rd_op1", S_OP1, 32'h12345678);
        expect_out("rd_op2", S_OP2, 32'hCAFEBABE);
        expect_out("imm_m00", S_IMM, 32'hFFFF8001);
        #1 check_pending();

        drive(mk(4'd4, 4'd5, 2'b01, 16'hABCD), 32'h0, 1'b0, 1'b0);
        expect_out("imm_m01", S_IMM, 32'h0000ABCD);
        #1 check_pending();

        drive(mk(4'd4, 4'd5, 2'b10, 16'h1234), 32'h0, 1'b0, 1'b0);
        expect_out("imm_m10", S_IMM, 32'h12340000);
        #1 check_pending();

        drive(mk(4'd4, 4'd5, 2'b11, 16'h8000), 32'h0, 1'b0, 1'b0);
        expect_out("imm_m11", S_IMM, 32'hFFFF8000);
        #1 check_pending();

        drive(mk(4'd4, 4'd5, 2'b00, 16'h7FFF), 32'h0, 1'b0, 1'b0);
        expect_out("imm_m00_pos", S_IMM, 32'h00007FFF);
        #1 check_pending();

        // Store swap, ret override, and both together.
        drive(mk(4'd4, 4'd5, 2'b00, 16'h0), 32'h0, 1'b0, 1'b1);
        expect_out("st_op1", S_OP1, 32'hCAFEBABE);
        expect_out("st_op2", S_OP2, 32'h12345678);
        #1 check_pending();

        drive(mk(4'd4, 4'd5, 2'b00, 16'h0), 32'h0, 1'b1, 1'b0);
        expect_out("ret_op1", S_OP1, 32'h0F0F0F0F);
        expect_out("ret_op2", S_OP2, 32'hCAFEBABE);
        #1 check_pending();

        drive(mk(4'd4, 4'd5, 2'b00, 16'h0), 32'h0, 1'b1, 1'b1);
        expect_out("retst_op1", S_OP1, 32'h0F0F0F0F);
        expect_out("retst_op2", S_OP2, 32'h12345678);
        #1 check_pending();

        // Branch targets, including negative offset and wraparound.
        drive(32'h00000002, 32'h10000000, 1'b0, 1'b0);
        expect_out("bt_off2", S_BT, 32'h10000008);
        #1 check_pending();

        drive(32'h07FFFFFF, 32'h10000000, 1'b0, 1'b0);
        expect_out("bt_neg1", S_BT, 32'h0FFFFFFC);
        #1 check_pending();

        drive(32'h00000001, 32'hFFFFFFFC, 1'b0, 1'b0);
        expect_out("bt_wrap", S_BT, 32'h00000000);
        #1 check_pending();

        drive(32'h04000000, 32'h00000000, 1'b0, 1'b0);
        expect_out("bt_minoff", S_BT, 32'hF0000000);
        #1 check_pending();

        // Reset beats a simultaneous write to r15.
        @(negedge clk);
        Reset = 1'b1;
        isWa  = 1'b1;
        wa    = 4'd15;
        wd    = 32'hDEADBEEF;
        @(negedge clk);
        Reset = 1'b0;
        isWa  = 1'b0;
        drive(mk(4'd4, 4'd15, 2'b00, 16'h0), 32'h0, 1'b1, 1'b0);
        expect_out("rstwr_r15", S_OP1, 32'h0);
        expect_out("rstwr_r15_b", S_OP2, 32'h0);
        #1 check_pending();

        // No bypass: old value during the write cycle, new value after the edge.
        write_reg(4'd7, 32'h11111111);
        @(negedge clk);
        inst  = mk(4'd7, 4'd4, 2'b00, 16'h0);
        isRet = 1'b0;
        isSt  = 1'b0;
        isWa  = 1'b1;
        wa    = 4'd7;
        wd    = 32'h22222222;
        expect_out("nobypass_old", S_OP1, 32'h11111111);
        expect_out("wr_other_r4", S_OP2, 32'h0);
        #1 check_pending();
        @(posedge clk);
        #1;
        expect_out("nobypass_new", S_OP1, 32'h22222222);
        expect_out("wr_other_r4_after", S_OP2, 32'h0);
        check_pending();

        // Disabled write leaves the register untouched.
        @(negedge clk);
        isWa = 1'b0;
        wd   = 32'h33333333;
        @(posedge clk);
        #1;
        expect_out("nowrite_r7", S_OP1, 32'h22222222);
        check_pending();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
